// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants, sync decode bounds, lock FSM
// state encoding and colour-bar palette for the 720x480p60 raster generator.
package vga_timing_pkg;

  // CEA-861 720x480p60 horizontal timing (pixel clocks)
  localparam int unsigned H_ACTIVE = 720;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 62;
  localparam int unsigned H_BP     = 60;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing (lines)
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 9;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 30;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync pulse decode bounds, half-open [START, END)
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Sync polarity (0 = active-low) and PLL lock settle time
  localparam bit          SYNC_POL  = 1'b0;
  localparam int unsigned LOCK_WAIT = 1024;

  // Lock qualification FSM states
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } lock_state_e;

  // Colour-bar test pattern: 8 bars of BAR_W pixels
  localparam int unsigned BAR_W       = 90;
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Map a bar index to its RGB888 colour
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      3'd7:    c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_lock_qual.sv
// vga_lock_qual: synchronises the PLL lock flag and only declares RUN once
// lock has been seen continuously for LOCK_WAIT+1 synchronised samples.
// run_next_o exposes the next-state decode so the raster can be blanked on
// the same edge that leaves RUN.
module vga_lock_qual
  import vga_timing_pkg::*;
#(
  parameter int unsigned LOCK_WAIT_P = LOCK_WAIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  output logic running_o,
  output logic run_next_o
);

  localparam int CW = (LOCK_WAIT_P > 1) ? $clog2(LOCK_WAIT_P) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_WAIT_P - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          locked_s;
  lock_state_e   state_q;
  lock_state_e   state_d;
  logic [CW-1:0] settle_q;
  logic [CW-1:0] settle_d;
  logic          running_q;

  assign locked_s = sync2_q;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and settle counter; a lock drop always has priority
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      WAIT_LOCK: begin
        settle_d = {CW{1'b0}};
        if (locked_s) begin
          state_d = SETTLE;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d  = WAIT_LOCK;
          settle_d = {CW{1'b0}};
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = RUN;
          settle_d = {CW{1'b0}};
        end else begin
          state_d  = SETTLE;
          settle_d = settle_q + CW'(1'b1);
        end
      end
      RUN: begin
        settle_d = {CW{1'b0}};
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d  = WAIT_LOCK;
        settle_d = {CW{1'b0}};
      end
    endcase
  end

  // State, settle counter and registered running flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WAIT_LOCK;
      settle_q  <= {CW{1'b0}};
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      running_q <= (state_d == RUN);
    end
  end

  assign running_o  = running_q;
  assign run_next_o = (state_d == RUN);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 720x480p60 raster timing generator. Waits for a qualified
// PLL lock, then runs h/v counters and registers sync, data-enable, pixel
// coordinates and a frame-start strobe one clock after the counters.
// Optional colour-bar output rgb is enabled by defining VGA_TIMING_TESTPAT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned P_H_ACTIVE  = H_ACTIVE,
  parameter int unsigned P_H_FP      = H_FP,
  parameter int unsigned P_H_SYNC    = H_SYNC,
  parameter int unsigned P_H_BP      = H_BP,
  parameter int unsigned P_V_ACTIVE  = V_ACTIVE,
  parameter int unsigned P_V_FP      = V_FP,
  parameter int unsigned P_V_SYNC    = V_SYNC,
  parameter int unsigned P_V_BP      = V_BP,
  parameter bit          P_SYNC_POL  = SYNC_POL,
  parameter int unsigned P_LOCK_WAIT = LOCK_WAIT
`ifdef VGA_TIMING_TESTPAT_EN
  ,
  parameter int unsigned P_BAR_W     = BAR_W
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        running
`ifdef VGA_TIMING_TESTPAT_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam logic [9:0] H_ACT_W  = 10'(P_H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [9:0] HS_START = 10'(P_H_ACTIVE + P_H_FP);
  localparam logic [9:0] HS_END   = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
  localparam logic [9:0] V_ACT_W  = 10'(P_V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
  localparam logic [9:0] VS_START = 10'(P_V_ACTIVE + P_V_FP);
  localparam logic [9:0] VS_END   = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC);
  localparam logic       SYNC_ACT = P_SYNC_POL;

  logic       running_s;
  logic       run_next_s;
  logic       adv_s;
  logic [9:0] h_cnt_q;
  logic [9:0] h_cnt_d;
  logic [9:0] v_cnt_q;
  logic [9:0] v_cnt_d;
  logic       h_act_s;
  logic       v_act_s;
  logic       hs_s;
  logic       vs_s;
  logic       de_s;
  logic       hsync_q;
  logic       vsync_q;
  logic       de_q;
  logic [9:0] pix_x_q;
  logic [8:0] pix_y_q;
  logic       frame_start_q;

  vga_lock_qual #(
    .LOCK_WAIT_P (P_LOCK_WAIT)
  ) u_lock_qual (
    .clk_i      (clk),
    .rst_i      (rst),
    .locked_i   (locked),
    .running_o  (running_s),
    .run_next_o (run_next_s)
  );

  // Raster advances only while in RUN and staying there; entry cycle holds (0,0)
  assign adv_s = running_s & run_next_s;

  // Raster counter next-state: line wrap bumps the line counter
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (adv_s) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = 10'd0;
      v_cnt_d = 10'd0;
    end
  end

  // Raster counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Region decode from the current counter values
  assign h_act_s = (h_cnt_q < H_ACT_W);
  assign v_act_s = (v_cnt_q < V_ACT_W);
  assign hs_s    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_s    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign de_s    = h_act_s & v_act_s;

  // Registered timing outputs, forced idle outside an advancing RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      de_q          <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 9'd0;
      frame_start_q <= 1'b0;
    end else if (adv_s) begin
      hsync_q       <= hs_s ? SYNC_ACT : ~SYNC_ACT;
      vsync_q       <= vs_s ? SYNC_ACT : ~SYNC_ACT;
      de_q          <= de_s;
      pix_x_q       <= de_s ? h_cnt_q : 10'd0;
      pix_y_q       <= de_s ? v_cnt_q[8:0] : 9'd0;
      frame_start_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end else begin
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      de_q          <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 9'd0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign running     = running_s;

`ifdef VGA_TIMING_TESTPAT_EN
  localparam logic [6:0] BAR_LAST = 7'(P_BAR_W - 1);

  logic [6:0]  bar_px_q;
  logic [6:0]  bar_px_d;
  logic [2:0]  bar_idx_q;
  logic [2:0]  bar_idx_d;
  logic [23:0] rgb_q;

  // Bar index tracks h_cnt with a pixel-in-bar counter instead of a divider
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (adv_s && (h_cnt_q != H_LAST)) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d = 7'd0;
        if (bar_idx_q != 3'd7) begin
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_idx_d = bar_idx_q;
        end
      end else begin
        bar_px_d  = bar_px_q + 7'd1;
        bar_idx_d = bar_idx_q;
      end
    end else begin
      bar_px_d  = 7'd0;
      bar_idx_d = 3'd0;
    end
  end

  // Bar counters and the colour register aligned with de
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_px_q  <= 7'd0;
      bar_idx_q <= 3'd0;
      rgb_q     <= 24'd0;
    end else begin
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= (adv_s && de_s) ? bar_color(bar_idx_q) : 24'd0;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with a reduced
// raster geometry. Expected outputs come from a time-based model: lock is
// qualified by a window of synchronised samples, and the raster position is
// elapsed clocks since RUN entry taken modulo the line/frame lengths.
module tb_vga_timing_gen;

  localparam int HA  = 24;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 6;
  localparam int VA  = 10;
  localparam int VFP = 2;
  localparam int VS  = 3;
  localparam int VBP = 4;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int LW  = 16;
  localparam int BW  = 3;
  localparam bit POL = 1'b0;
  localparam int MAXE = 30000;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [9:0]  px;
    logic [8:0]  py;
    logic        fs;
    logic        run;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b0;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        frame_start;
  logic        running;
`ifdef VGA_TIMING_TESTPAT_EN
  logic [23:0] rgb;
`endif

  exp_t        sb_q[$];
  exp_t        mexp;
  bit          samp [0:MAXE-1];
  bit          run_m[0:MAXE-1];
  int          e_idx = 0;
  int          run_start = 0;
  int          mon_idx = 0;
  int          de_run = 0;
  logic        de_prev = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_timing_gen #(
    .P_H_ACTIVE  (HA),
    .P_H_FP      (HFP),
    .P_H_SYNC    (HS),
    .P_H_BP      (HBP),
    .P_V_ACTIVE  (VA),
    .P_V_FP      (VFP),
    .P_V_SYNC    (VS),
    .P_V_BP      (VBP),
    .P_SYNC_POL  (POL),
    .P_LOCK_WAIT (LW)
`ifdef VGA_TIMING_TESTPAT_EN
    ,
    .P_BAR_W     (BW)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .running     (running)
`ifdef VGA_TIMING_TESTPAT_EN
    ,
    .rgb         (rgb)
`endif
  );

  always #5 clk = ~clk;

  // Drive one clock of stimulus and push the response expected after that edge
  task automatic step(input logic r, input logic l);
    exp_t x;
    int   t;
    int   h;
    int   v;
    bit   ok;
    @(negedge clk);
    rst    = r;
    locked = l;
    if (e_idx >= MAXE) begin
      $display("FAIL model_budget: edge %0d, limit %0d", e_idx, MAXE);
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "model budget exhausted");
    end
    x.hs  = !POL;
    x.vs  = !POL;
    x.de  = 1'b0;
    x.px  = 10'd0;
    x.py  = 9'd0;
    x.fs  = 1'b0;
    x.run = 1'b0;
    x.rgb = 24'd0;
    if (r) begin
      samp[e_idx] = 1'b0;
      if (e_idx > 0) samp[e_idx-1] = 1'b0;
      run_m[e_idx] = 1'b0;
    end else begin
      samp[e_idx] = l;
      ok = (e_idx >= 2 + LW);
      for (int k = e_idx - 2 - LW; ok && k <= e_idx - 2; k++) begin
        if (!samp[k]) ok = 1'b0;
      end
      run_m[e_idx] = ok;
      x.run = ok;
      if (ok && e_idx > 0 && run_m[e_idx-1]) begin
        t = e_idx - 1 - run_start;
        h = t % HT;
        v = (t / HT) % VT;
        x.de  = (h < HA) && (v < VA);
        x.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? POL : !POL;
        x.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? POL : !POL;
        x.px  = x.de ? 10'(h) : 10'd0;
        x.py  = x.de ? 9'(v) : 9'd0;
        x.fs  = (h == 0) && (v == 0);
        x.rgb = x.de ? bars[h / BW] : 24'd0;
      end else if (ok) begin
        run_start = e_idx;
      end
    end
    sb_q.push_back(x);
    e_idx++;
  endtask

  // Monitor: pop one expectation per clock and compare after the edge
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mexp = sb_q.pop_front();
      n_tests++;
      if ({hsync, vsync, de, pix_x, pix_y, frame_start, running} !==
          {mexp.hs, mexp.vs, mexp.de, mexp.px, mexp.py, mexp.fs, mexp.run}) begin
        n_fail++;
        $display("FAIL raster cycle %0d: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b run=%b, want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b run=%b",
                 mon_idx, hsync, vsync, de, pix_x, pix_y, frame_start, running,
                 mexp.hs, mexp.vs, mexp.de, mexp.px, mexp.py, mexp.fs, mexp.run);
      end
`ifdef VGA_TIMING_TESTPAT_EN
      n_tests++;
      if (rgb !== mexp.rgb) begin
        n_fail++;
        $display("FAIL rgb cycle %0d: got %06h, want %06h", mon_idx, rgb, mexp.rgb);
      end
`endif
      if (!de && de_prev && running) begin
        n_tests++;
        if (de_run != HA) begin
          n_fail++;
          $display("FAIL de_run_length cycle %0d: got %0d, want %0d", mon_idx, de_run, HA);
        end
      end
      de_run  = de ? de_run + 1 : 0;
      de_prev = de;
      mon_idx++;
    end
  end

  // Stimulus: directed lock scenarios followed by randomised lock/reset activity
  initial begin
    int len;
    bit lvl;
    bit rr;
    repeat (5) step(1'b1, 1'b0);
    // qualify lock, then two full frames, then drop mid-line (line 5, pixel 10)
    repeat (2 + LW + 1 + 2 * HT * VT + 5 * HT + 10) step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    // re-qualify and restart from (0,0)
    repeat (2 + LW + 1 + 2 * HT) step(1'b0, 1'b1);
    // one-clock lock glitch during settle
    repeat (3) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (2 + LW + 5 + HT) step(1'b0, 1'b1);
    // reset mid-frame with lock held high
    repeat (2) step(1'b1, 1'b1);
    repeat (2 + LW + 3 * HT) step(1'b0, 1'b1);
    // randomised lock toggling with occasional resets
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, 80);
      lvl = ($urandom_range(0, 9) > 2);
      rr  = ($urandom_range(0, 19) == 0);
      if (rr) step(1'b1, lvl);
      repeat (len) step(1'b0, lvl);
    end
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
